uart_rx_fifo: RTL

Receive-side buffer between the UART deserializer's byte stream and the CPU register port. Accepts received bytes on a valid/ready stream, stores up to 2^DEPTH_LOG2 bytes, and presents them first-word-fall-through to the register interface. Tracks fill level, raises a threshold interrupt, and records dropped bytes in a sticky overrun flag. A single clock domain on `clk`.

---
 rtl/uart_pkg.sv | 11 +
 rtl/uart_fifo_ram.sv | 34 +++
 rtl/uart_rx_fifo.sv | 118 +++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants
// Constants shared by the deserializer, the receive FIFO and the register
// interface.
//   UART_DATA_W            : width of one received character
//   UART_RXFIFO_DEPTH_LOG2 : log2 of the default receive FIFO depth
package uart_pkg;

  localparam int UART_DATA_W            = 8;
  localparam int UART_RXFIFO_DEPTH_LOG2 = 4;

endpackage

// File: rtl/uart_fifo_ram.sv
// rtl/uart_fifo_ram.sv - simple dual-port storage array for the UART FIFO
// One synchronous write port and one combinational read port. The array has
// no reset, so its contents are undefined until written.
//   clk   : write clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : read data, combinational from raddr
module uart_fifo_ram
  import uart_pkg::*;
#(
  parameter int WIDTH      = UART_DATA_W,
  parameter int DEPTH_LOG2 = UART_RXFIFO_DEPTH_LOG2
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  logic [WIDTH-1:0]      wdata,
  input  logic [DEPTH_LOG2-1:0] raddr,
  output logic [WIDTH-1:0]      rdata
);

  logic [WIDTH-1:0] mem [0:(1 << DEPTH_LOG2)-1];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - UART receive FIFO between deserializer and registers
// First-word-fall-through byte buffer with fill level, threshold interrupt
// and a sticky overrun flag (drop-newest when full, no backpressure).
//   clk, rst      : clock and asynchronous active-high reset
//   in_tdata      : received byte from the deserializer
//   in_tvalid     : in_tdata valid
//   in_tready     : registered, 1 from the first edge after reset
//   out_tdata     : oldest stored byte
//   out_tvalid    : FIFO non-empty
//   out_tready    : pop strobe from the register read
//   flush         : synchronous clear of the contents
//   threshold     : interrupt fill threshold, 0 disables
//   level         : number of stored bytes
//   full          : level equals the depth
//   thr_irq       : registered, level >= threshold and threshold != 0
//   overrun       : sticky, a byte was dropped because the FIFO was full
//   overrun_clr   : synchronous clear of overrun
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH_LOG2 = UART_RXFIFO_DEPTH_LOG2,
  parameter int WIDTH      = UART_DATA_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDTH-1:0]      in_tdata,
  input  logic                  in_tvalid,
  output logic                  in_tready,
  output logic [WIDTH-1:0]      out_tdata,
  output logic                  out_tvalid,
  input  logic                  out_tready,
  input  logic                  flush,
  input  logic [DEPTH_LOG2:0]   threshold,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  full,
  output logic                  thr_irq,
  output logic                  overrun,
  input  logic                  overrun_clr
);

  localparam int              LW        = DEPTH_LOG2 + 1;
  localparam logic [LW-1:0]   DEPTH_LVL = LW'(1 << DEPTH_LOG2);

  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [LW-1:0]         level_q;
  logic [LW-1:0]         level_nxt;
  logic                  in_fire;
  logic                  pop_ok;
  logic                  push_ok;
  logic                  drop;

  assign level      = level_q;
  assign out_tvalid = (level_q != '0);
  assign full       = (level_q == DEPTH_LVL);

  // Flush wins over everything; a push while full only lands if a pop on the
  // same edge frees the slot, otherwise it is dropped and flagged.
  assign in_fire = in_tvalid & in_tready;
  assign pop_ok  = out_tvalid & out_tready & ~flush;
  assign push_ok = in_fire & ~flush & (~full | pop_ok);
  assign drop    = in_fire & ~flush & full & ~pop_ok;

  always_comb begin
    level_nxt = level_q;
    if (flush) begin
      level_nxt = '0;
    end else begin
      case ({push_ok, pop_ok})
        2'b10:   level_nxt = level_q + LW'(1);
        2'b01:   level_nxt = level_q - LW'(1);
        default: level_nxt = level_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_tready <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level_q   <= '0;
      thr_irq   <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      in_tready <= 1'b1;
      level_q   <= level_nxt;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push_ok) wr_ptr <= wr_ptr + 1'b1;
        if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      end
      // Interrupt follows the level the FIFO is about to hold.
      thr_irq <= (threshold != '0) && (level_nxt >= threshold);
      // A drop on the same edge as a clear keeps the flag set.
      if (drop) begin
        overrun <= 1'b1;
      end else if (overrun_clr) begin
        overrun <= 1'b0;
      end
    end
  end

  uart_fifo_ram #(
    .WIDTH      (WIDTH),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_ram (
    .clk   (clk),
    .we    (push_ok),
    .waddr (wr_ptr),
    .wdata (in_tdata),
    .raddr (rd_ptr),
    .rdata (out_tdata)
  );

endmodule
